mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter (instruction fetch + data memory) onto one shared memory port.
// Data requests win by default; a starvation counter hands the port to a waiting fetch
// after STARVE_MAX consecutive data grants.
// Optional performance counters are built only when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              busy,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_dm_grants,
    output logic [31:0]       perf_wait_cycles
);

    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StGntIf, StGntDm} state_e;

    state_e              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic [StarveW-1:0]  starve_q, starve_d;
    logic                if_elig, dm_elig, if_grant, dm_grant;

    // A requester still showing its just-acked request must not be granted again.
    assign if_elig = if_req & ~if_ack_q;
    assign dm_elig = dm_req & ~dm_ack_q;

    // Next-state, arbitration and completion handling.
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        starve_d    = starve_q;
        if_grant    = 1'b0;
        dm_grant    = 1'b0;
        case (state_q)
            StIdle: begin
                // Winner is picked on raw requests; it is granted only if eligible.
                // A data master in its ack cycle thus blocks the fetch for one cycle,
                // keeping back-to-back data ops counted against the starvation limit.
                if (if_req && starve_q == StarveMax) begin
                    if_grant = if_elig;
                end else if (dm_req) begin
                    dm_grant = dm_elig;
                end else begin
                    if_grant = if_elig;
                end
                if (if_grant) begin
                    state_d     = StGntIf;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end else if (dm_grant) begin
                    state_d     = StGntDm;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + StarveW'(1);
                    end
                end else if (!if_req) begin
                    starve_d = '0;
                end
            end
            StGntIf: begin
                if (mem_ready) begin
                    state_d    = StIdle;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            StGntDm: begin
                if (mem_ready) begin
                    state_d  = StIdle;
                    dm_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_req   = (state_q != StIdle);
    assign busy      = (state_q != StIdle);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall     = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] perf_if_q, perf_if_d, perf_dm_q, perf_dm_d, perf_wait_q, perf_wait_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        perf_if_d   = perf_if_q + {31'd0, if_grant};
        perf_dm_d   = perf_dm_q + {31'd0, dm_grant};
        perf_wait_d = perf_wait_q + {31'd0, stall};
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_q   <= '0;
            perf_dm_q   <= '0;
            perf_wait_q <= '0;
        end else begin
            perf_if_q   <= perf_if_d;
            perf_dm_q   <= perf_dm_d;
            perf_wait_q <= perf_wait_d;
        end
    end

    assign perf_if_grants   = perf_if_q;
    assign perf_dm_grants   = perf_dm_q;
    assign perf_wait_cycles = perf_wait_q;
`else
    assign perf_if_grants   = 32'd0;
    assign perf_dm_grants   = 32'd0;
    assign perf_wait_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, dm-over-if priority, held write,
// starvation limit, and reset during a data grant.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_req, mem_we, stall, busy;
    logic [31:0] perf_if_grants, perf_dm_grants, perf_wait_cycles;

    int checks = 0;
    int failures = 0;

`ifdef MEM_ARBITER_PERF_EN
    localparam logic [31:0] ExpDmAfterRst = 32'd1;
`else
    localparam logic [31:0] ExpDmAfterRst = 32'd0;
`endif

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .if_ack           (if_ack),
        .dm_req           (dm_req),
        .dm_we            (dm_we),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_rdata         (dm_rdata),
        .dm_ack           (dm_ack),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .stall            (stall),
        .busy             (busy),
        .perf_if_grants   (perf_if_grants),
        .perf_dm_grants   (perf_dm_grants),
        .perf_wait_cycles (perf_wait_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int  dm_grants;
        bit  if_granted;
        bit  done;
        logic prev_req;

        rst = 1'b1;
        if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_acks", {if_ack, dm_ack}, 0);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        check("rst_perf", {perf_if_grants, perf_dm_grants}, 0);
        rst = 1'b0;

        // Single fetch, memory ready on the first grant cycle.
        if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h0050_0093;
        tick();
        check("if_grant_req", mem_req, 1);
        check("if_grant_addr", mem_addr, 32'h10);
        check("if_grant_we", mem_we, 0);
        check("if_grant_ack_early", if_ack, 0);
        check("if_grant_stall", stall, 1);
        tick();
        check("if_ack", if_ack, 1);
        check("if_rdata", if_rdata, 32'h0050_0093);
        check("if_ack_mem_req", mem_req, 0);
        check("if_ack_stall", stall, 0);
        if_req = 0; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("if_ack_pulse", if_ack, 0);
        check("if_rdata_held", if_rdata, 32'h0050_0093);

        // Simultaneous fetch and data read: data goes first.
        if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        tick();
        check("pri_dm_addr", mem_addr, 32'h40);
        check("pri_dm_we", mem_we, 0);
        check("pri_stall", stall, 1);
        mem_ready = 1; mem_rdata = 32'h0000_1234;
        tick();
        check("pri_dm_ack", dm_ack, 1);
        check("pri_dm_rdata", dm_rdata, 32'h1234);
        check("pri_if_wait", if_ack, 0);
        check("pri_stall_wait", stall, 1);
        dm_req = 0; mem_rdata = 32'h0000_AAAA;
        tick();
        check("pri_if_grant_addr", mem_addr, 32'h20);
        check("pri_if_grant_wd", {mem_we, mem_wdata}, 0);
        check("pri_if_grant_req", mem_req, 1);
        check("pri_stall_if", stall, 1);
        tick();
        check("pri_if_ack", if_ack, 1);
        check("pri_if_rdata", if_rdata, 32'hAAAA);
        check("pri_dm_rdata_held", dm_rdata, 32'h1234);
        check("pri_stall_done", stall, 0);
        if_req = 0; mem_ready = 0;
        tick();

        // Write with three wait cycles; requester inputs change mid-grant.
        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            tick();
            dm_addr = 32'h999; dm_wdata = 32'h0; dm_we = 0;
            check("wr_req", mem_req, 1);
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, 32'h80);
            check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("wr_no_ack", dm_ack, 0);
            if (i == 3) mem_ready = 1;
        end
        tick();
        check("wr_ack", dm_ack, 1);
        check("wr_rdata_unchanged", dm_rdata, 32'h1234);
        dm_req = 0; mem_ready = 0;
        tick();
        check("wr_ack_pulse", dm_ack, 0);

        // Starvation limit: data held, fetch waiting, memory always ready.
        if_req = 1; if_addr = 32'h30; dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        dm_grants = 0; if_granted = 0; done = 0; prev_req = mem_req;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            tick();
            if (mem_req && !prev_req) begin
                if (mem_addr == 32'h30) begin
                    if_granted = 1;
                    check("starve_cleared", dut.starve_q, 0);
                end else if (!if_granted) begin
                    dm_grants++;
                end
            end
            if (if_ack) begin
                done = 1;
                if_req = 0; dm_req = 0; mem_ready = 0;
            end
            prev_req = mem_req;
        end
        check("starve_if_done", done, 1);
        check("starve_dm_grants", dm_grants, 4);
        check("starve_if_granted", if_granted, 1);
        check("starve_if_rdata", if_rdata, 32'h0BAD_F00D);
        tick(); tick();

        // Reset in the middle of a data grant.
        dm_req = 1; dm_we = 0; dm_addr = 32'h200; mem_ready = 0;
        tick();
        check("rg_grant", mem_req, 1);
        #2 rst = 1;
        #1;
        check("rg_async_req", mem_req, 0);
        check("rg_async_busy", busy, 0);
        check("rg_async_addr", mem_addr, 0);
        mem_ready = 1; mem_rdata = 32'h7777;
        tick(); tick();
        check("rg_no_ack", dm_ack, 0);
        check("rg_rdata_clr", dm_rdata, 0);
        check("rg_perf_zero", perf_dm_grants, 0);
        rst = 0;
        tick();
        check("rg_rearb_req", mem_req, 1);
        check("rg_rearb_addr", mem_addr, 32'h200);
        check("rg_ready_ignored", dm_ack, 0);
        check("rg_perf_dm", perf_dm_grants, ExpDmAfterRst);
        tick();
        check("rg_ack", dm_ack, 1);
        check("rg_rdata", dm_rdata, 32'h7777);
        dm_req = 0; mem_ready = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
